// File: rtl/quad_encoder_emulator.sv
// Quadrature A/B generator driven by signed edge-count commands.
// Optional index output (quadZ) is built when QUAD_INDEX_EN is defined.
module quad_encoder_emulator #(
   parameter int unsigned PERIOD_WIDTH = 16,
   parameter int unsigned INDEX_CPR    = 2048
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic signed [15:0]      cmd_steps,
   input  logic [PERIOD_WIDTH-1:0] edge_period,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    abort,
   output logic                    quadA,
   output logic                    quadB,
   output logic                    quadZ,
   output logic                    busy,
   output logic                    done,
   output logic signed [31:0]      position
);

   localparam int unsigned STEP_W = 16;
   localparam int unsigned POS_W  = 32;

   typedef enum logic {IDLE, RUN} state_t;

   state_t                  state, state_n;
   logic [1:0]              phase, phase_n;
   logic [STEP_W-1:0]       remaining, remaining_n;
   logic [PERIOD_WIDTH-1:0] timer, timer_n;
   logic [PERIOD_WIDTH-1:0] period, period_n;
   logic                    dir, dir_n;
   logic signed [POS_W-1:0] position_n;
   logic                    done_n;
   logic                    emit_c;

   // Next-state, move bookkeeping and edge generation
   always_comb begin
      state_n     = state;
      phase_n     = phase;
      remaining_n = remaining;
      timer_n     = timer;
      period_n    = period;
      dir_n       = dir;
      position_n  = position;
      done_n      = 1'b0;
      emit_c      = 1'b0;
      case (state)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               if (cmd_steps == 16'sd0) begin
                  done_n = 1'b1;
               end else begin
                  remaining_n = cmd_steps[15] ? STEP_W'(-cmd_steps) : STEP_W'(cmd_steps);
                  dir_n       = ~cmd_steps[15];
                  period_n    = (edge_period == '0) ? PERIOD_WIDTH'(1) : edge_period;
                  timer_n     = period_n;
                  state_n     = RUN;
               end
            end
         end
         RUN: begin
            if (abort) begin
               state_n = IDLE;
            end else if (timer == PERIOD_WIDTH'(1)) begin
               emit_c      = 1'b1;
               timer_n     = period;
               remaining_n = remaining - STEP_W'(1);
               if (remaining == STEP_W'(1)) begin
                  state_n = IDLE;
                  done_n  = 1'b1;
               end
            end else begin
               timer_n = timer - PERIOD_WIDTH'(1);
            end
         end
         default: state_n = IDLE;
      endcase
      if (emit_c) begin
         phase_n    = dir ? phase + 2'd1 : phase - 2'd1;
         position_n = dir ? position + 32'sd1 : position - 32'sd1;
      end
   end

   // Phase index 0..3 maps to {A,B} = 00,10,11,01
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         phase     <= 2'd0;
         remaining <= '0;
         timer     <= '0;
         period    <= '0;
         dir       <= 1'b0;
         position  <= '0;
         quadA     <= 1'b0;
         quadB     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         cmd_ready <= 1'b0;
      end else begin
         state     <= state_n;
         phase     <= phase_n;
         remaining <= remaining_n;
         timer     <= timer_n;
         period    <= period_n;
         dir       <= dir_n;
         position  <= position_n;
         quadA     <= phase_n[1] ^ phase_n[0];
         quadB     <= phase_n[1];
         busy      <= (state_n == RUN);
         done      <= done_n;
         cmd_ready <= (state_n == IDLE);
      end
   end

`ifdef QUAD_INDEX_EN
   localparam int unsigned IDX_W = (INDEX_CPR > 1) ? $clog2(INDEX_CPR) : 1;

   logic [IDX_W-1:0] idx, idx_n;

   // Index counter wraps in both directions so Z marks one mechanical point
   always_comb begin
      idx_n = idx;
      if (emit_c) begin
         if (dir) idx_n = (idx == IDX_W'(INDEX_CPR - 1)) ? '0 : idx + IDX_W'(1);
         else     idx_n = (idx == '0) ? IDX_W'(INDEX_CPR - 1) : idx - IDX_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx   <= '0;
         quadZ <= 1'b0;
      end else begin
         idx   <= idx_n;
         quadZ <= (idx_n == '0) && (phase_n == 2'd0);
      end
   end
`else
   assign quadZ = 1'b0;
`endif

endmodule

// File: tb/tb_quad_encoder_emulator.sv
// Directed bench for quad_encoder_emulator with an edge scoreboard and decoder model.
module tb_quad_encoder_emulator;

   localparam int unsigned PW  = 16;
   localparam int          CPR = 8;

   logic                 clk = 1'b0;
   logic                 reset;
   logic signed [15:0]   cmd_steps;
   logic [PW-1:0]        edge_period;
   logic                 cmd_valid;
   logic                 cmd_ready;
   logic                 abort;
   logic                 quadA, quadB, quadZ;
   logic                 busy, done;
   logic signed [31:0]   position;

   quad_encoder_emulator #(.PERIOD_WIDTH(PW), .INDEX_CPR(CPR)) dut (
      .clk(clk), .reset(reset), .cmd_steps(cmd_steps), .edge_period(edge_period),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .abort(abort),
      .quadA(quadA), .quadB(quadB), .quadZ(quadZ),
      .busy(busy), .done(done), .position(position)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]         ab;
      logic               z;
      logic signed [31:0] pos;
      int                 cyc;
   } exp_t;

   exp_t               sb[$];
   int                 n_assert = 0;
   int                 n_fail = 0;
   int                 cyc = 0;
   logic [1:0]         seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
   logic [1:0]         phase_m = 2'd0;
   logic signed [31:0] pos_m = 0;
   int                 idx_m = 0;
   logic signed [31:0] dec_cnt = 0;
   logic [1:0]         prev_ab = 2'b00;
   logic [1:0]         ab;
   exp_t               e;
   int                 done_cnt = 0;
   int                 done_cyc = -1;
   int                 busy_cnt = 0;
   int                 acc;
   logic signed [31:0] p0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_assert++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // Monitor: scoreboard pop on every A/B change plus an x4 decoder
   always @(negedge clk) begin
      if (reset) begin
         prev_ab = 2'b00;
      end else begin
         ab = {quadA, quadB};
         if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
         if (busy === 1'b1) busy_cnt++;
         if (ab != prev_ab) begin
            chk("one_toggle", 32'($countones(ab ^ prev_ab)), 32'd1);
            case ({prev_ab, ab})
               4'b0010, 4'b1011, 4'b1101, 4'b0100: dec_cnt = dec_cnt + 1;
               4'b0001, 4'b0111, 4'b1110, 4'b1000: dec_cnt = dec_cnt - 1;
               default: ;
            endcase
            if (sb.size() == 0) begin
               chk("unexpected_edge", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               chk("edge_ab", 32'(ab), 32'(e.ab));
               chk("edge_pos", position, e.pos);
               chk("edge_z", 32'(quadZ), 32'(e.z));
               chk("edge_cycle", cyc, e.cyc);
            end
            prev_ab = ab;
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic push_move(input int dir, input int n, input int per, input int a);
      exp_t x;
      for (int k = 1; k <= n; k++) begin
         phase_m = (dir > 0) ? phase_m + 2'd1 : phase_m - 2'd1;
         pos_m   = pos_m + dir;
         idx_m   = (idx_m + dir + CPR) % CPR;
         x.ab    = seq[phase_m];
`ifdef QUAD_INDEX_EN
         x.z     = (idx_m == 0) && (phase_m == 2'd0);
`else
         x.z     = 1'b0;
`endif
         x.pos   = pos_m;
         x.cyc   = a + k * per;
         sb.push_back(x);
      end
   endtask

   task automatic issue(input int steps, input int per, output int a);
      chk("ready_before_cmd", 32'(cmd_ready), 32'd1);
      cmd_steps   = 16'(steps);
      edge_period = PW'(per);
      cmd_valid   = 1'b1;
      a           = cyc + 1;
   endtask

   task automatic wait_idle(input int maxc);
      int k = 0;
      while (busy === 1'b1 && k < maxc) begin
         step();
         k++;
      end
      if (k >= maxc) chk("idle_timeout", 32'd1, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; cmd_valid = 1'b0; abort = 1'b0; cmd_steps = '0; edge_period = '0;
      step(); step();
      chk("rst_quadA", 32'(quadA), 32'd0);
      chk("rst_quadB", 32'(quadB), 32'd0);
      chk("rst_quadZ", 32'(quadZ), 32'd0);
      chk("rst_position", position, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      reset = 1'b0;
      step();
      chk("ready_after_reset", 32'(cmd_ready), 32'd1);

      // +4 edges, period 10
      issue(4, 10, acc);
      push_move(1, 4, 10, acc);
      busy_cnt = 0; done_cnt = 0;
      step();
      cmd_valid = 1'b0;
      chk("t1_busy", 32'(busy), 32'd1);
      chk("t1_ready_low", 32'(cmd_ready), 32'd0);
      wait_idle(60);
      chk("t1_position", position, 32'sd4);
      chk("t1_done_cnt", done_cnt, 32'd1);
      chk("t1_done_cyc", done_cyc, acc + 40);
      chk("t1_busy_cycles", busy_cnt, 32'd40);
      chk("t1_sb_empty", sb.size(), 32'd0);
      step();
      chk("t1_done_one_cycle", 32'(done), 32'd0);

      // -3 edges, period 0 treated as 1; extra command held during RUN
      issue(-3, 0, acc);
      push_move(-1, 3, 1, acc);
      step();
      cmd_steps = 16'sd77;
      chk("t2_ready_low", 32'(cmd_ready), 32'd0);
      step(); step(); step();
      cmd_valid = 1'b0;
      chk("t2_idle", 32'(busy), 32'd0);
      chk("t2_position", position, pos_m);
      repeat (5) step();
      chk("t2_no_extra_move", 32'(busy), 32'd0);
      chk("t2_sb_empty", sb.size(), 32'd0);

      // +100 period 5, abort on the clock of the 7th edge
      issue(100, 5, acc);
      push_move(1, 6, 5, acc);
      done_cnt = 0;
      step();
      cmd_valid = 1'b0;
      while (cyc < acc + 34) step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("t3_busy", 32'(busy), 32'd0);
      chk("t3_ready", 32'(cmd_ready), 32'd1);
      chk("t3_position", position, pos_m);
      repeat (20) step();
      chk("t3_no_done", done_cnt, 32'd0);
      chk("t3_sb_empty", sb.size(), 32'd0);

      // zero-step command
      p0 = pos_m;
      issue(0, 7, acc);
      step();
      cmd_valid = 1'b0;
      chk("t4_done", 32'(done), 32'd1);
      chk("t4_busy", 32'(busy), 32'd0);
      step();
      chk("t4_done_low", 32'(done), 32'd0);
      chk("t4_position", position, p0);

      // back-to-back +2 then -2, second held valid
      issue(2, 3, acc);
      push_move(1, 2, 3, acc);
      step();
      cmd_steps = -16'sd2;
      push_move(-1, 2, 3, acc + 7);
      while (cyc < acc + 7) step();
      cmd_valid = 1'b0;
      chk("t5_second_busy", 32'(busy), 32'd1);
      wait_idle(40);
      chk("t5_position", position, p0);
      chk("t5_decoder", dec_cnt, position);
      chk("t5_sb_empty", sb.size(), 32'd0);

      // index sweep: +16 then -8 at one edge per clock
      issue(16, 1, acc);
      push_move(1, 16, 1, acc);
      step();
      cmd_valid = 1'b0;
      wait_idle(40);
      issue(-8, 1, acc);
      push_move(-1, 8, 1, acc);
      step();
      cmd_valid = 1'b0;
      wait_idle(40);
      chk("t6_position", position, pos_m);
      chk("t6_decoder", dec_cnt, position);
      chk("t6_sb_empty", sb.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/quad_encoder_emulator.md
Name: quad_encoder_emulator

Overview:
- Generates A/B quadrature signals from signed step commands; the transmit-side counterpart of the board's quadrature decoder.
- Uses: encoder emulation for closed-loop bench tests, and re-exporting a motor position to an external controller as quadrature.
- One command moves N quadrature edges, one every edge_period clocks, in the commanded direction.

Parameters:
- PERIOD_WIDTH, 16, width of edge_period and of the internal edge timer.
- INDEX_CPR, 2048, counts (edges) per revolution for the index output; used only with QUAD_INDEX_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cmd_steps  in  16  signed edge count; sign sets direction, positive = A leads B
- edge_period  in  PERIOD_WIDTH  clocks between edges; 0 is treated as 1
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- abort  in  1  stop the current move
- quadA  out  1  quadrature channel A
- quadB  out  1  quadrature channel B
- quadZ  out  1  index pulse
- busy  out  1  move in progress
- done  out  1  one-cycle pulse when a move completes normally
- position  out  32  signed running count of emitted edges

Behaviour:
- Reset, asynchronous:
  - Outputs: quadA=0, quadB=0, quadZ=0, position=0, busy=0, done=0, cmd_ready=0.
  - State: IDLE, phase=0, remaining=0, timer=0.
  - cmd_ready goes to 1 on the first clock after reset deasserts.
- States are IDLE and RUN.
- IDLE:
  - cmd_ready=1, busy=0.
  - A command is accepted on the edge where cmd_valid&&cmd_ready.
  - cmd_steps==0: stay in IDLE, pulse done on the next cycle, no edge.
  - Otherwise latch:
    - remaining = |cmd_steps| as 16-bit unsigned; -32768 gives 32768.
    - dir = sign of cmd_steps.
    - period = max(edge_period,1).
    - timer = period.
  - Then go to RUN: cmd_ready=0, busy=1.
  - abort is ignored in IDLE.
- RUN:
  - timer decrements each clock.
  - On the clock where timer==1, emit one edge, reload timer=period and decrement remaining.
  - First edge lands exactly period clocks after the acceptance edge; later edges follow every period clocks.
  - edge_period changes during RUN have no effect.
  - cmd_valid during RUN is ignored (cmd_ready=0).
- Edge emission:
  - Phase is 2 bits; {A,B} sequence 00→10→11→01→00 for dir positive, reverse for negative.
  - This sequence increments the board's decoder.
  - Exactly one of A/B toggles per edge.
  - position changes ±1 on the same clock edge as A/B, with 32-bit two's-complement wrap.
- Completion:
  - On the edge emitting the last edge (remaining 1→0): go to IDLE, cmd_ready=1, busy=0.
  - done=1 for exactly the following cycle.
  - A new command can be accepted on the next edge; its first edge arrives period clocks later.
  - Emitted edges are never closer than min(period_old, period_new) clocks.
- Abort:
  - abort high in RUN: go to IDLE on that edge; no further edges, done stays 0.
  - A/B and position hold their current values.
  - abort has priority over an edge due on the same clock; that edge is suppressed.
- Persistence across commands:
  - Phase and position are never cleared except by reset.
  - Output continuity is preserved across commands and direction reversals.
- quadA/quadB/quadZ are driven directly from flops; no combinational path from inputs.
- Users must set edge_period above the receiver's noise-filter length plus 2 clocks. The block does not enforce this.

Optional Feature:
- Macro: QUAD_INDEX_EN.
- Defined:
  - An index counter 0..INDEX_CPR-1 tracks edges: increments on +dir edges, decrements on -dir edges, and wraps at both ends.
  - quadZ=1 while the index counter==0 and {A,B}==00; it changes on the same edge as A/B.
  - Reset sets the index counter to 0, so quadZ=0 at reset because quadZ is registered.
  - After the first full revolution quadZ marks the same mechanical point in both directions.
- Undefined: quadZ is tied 0 and no index logic is built.

Test Plan:
- Reset release, then cmd_steps=+4, edge_period=10 → edges at +10,+20,+30,+40 clocks; {A,B}=10,11,01,00; position=4; done one cycle after the 4th edge; busy high 40 cycles.
- cmd_steps=-3, edge_period=0 → one edge per clock; {A,B}=01,11,10 from 00; position=-3; cmd_valid during RUN not accepted.
- cmd_steps=+100, period 5, abort on the clock of the 7th edge → exactly 6 edges, position=6, done never asserted, cmd_ready=1 next cycle.
- cmd_steps=0 → no A/B toggle, done pulses once, busy stays 0.
- Back-to-back: +2 then -2 with period 3, second command held valid → position returns to 0; edge spacing ≥3 clocks; A/B never toggle together. Loop into the decoder: decoder count matches position.
- QUAD_INDEX_EN with INDEX_CPR=8, +16 steps period 1 → quadZ high at edges 8 and 16 only. Then -8 steps → quadZ high once at the end of the move.
